coin_input_conditioner: RTL and testbench
=========================================

Name: coin_input_conditioner

Overview:
- Front-end stage directly upstream of the Vending FSM.
- Takes raw, asynchronous, bouncy coin-slot and button contacts and synchronises and debounces them.
- Converts each accepted coin into exactly one single-cycle, mutually exclusive quarter/dime/nickel pulse, queuing coins that arrive together.
- Presents clean soda/diet selection levels.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clocks a synchronised input must hold a new value before it is accepted (min 1).
- GAP_CYCLES, 2: idle clocks forced between two coin pulses (min 1).
- PEND_MAX, 3: per-coin-type pending queue depth (saturating count; count width = clog2(PEND_MAX+1)).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- quarter_raw  in  1  raw quarter-slot contact, async, may bounce
- dime_raw  in  1  raw dime-slot contact
- nickel_raw  in  1  raw nickel-slot contact
- soda_raw  in  1  raw soda button
- diet_raw  in  1  raw diet button
- quarter  out  1  one-cycle pulse per accepted quarter
- dime  out  1  one-cycle pulse per accepted dime
- nickel  out  1  one-cycle pulse per accepted nickel
- soda  out  1  clean soda selection level
- diet  out  1  clean diet selection level
- sel_conflict  out  1  high while both buttons are stably pressed
- coin_lost  out  1  one-cycle pulse when a coin is dropped on queue overflow

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - all synchroniser flops, debounced states, debounce counters, pending counts and the gap counter go to 0;
  - all outputs go to 0.
- Reset taken mid-operation discards pending coins, with no pulse on release.
- Synchroniser: 2 flops per channel, 5 channels.
- Debounce, per channel:
  - counter increments while the synchronised value differs from the stable value;
  - counter clears whenever the two match;
  - when the counter reaches DEBOUNCE_CYCLES, the stable value flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES clocks are ignored.
- Coin event: stable coin state rises 0->1. A falling edge produces nothing.
- Pending counts, per type:
  - an event increments the count;
  - an issue decrements it;
  - an event and an issue of the same type in the same cycle leave the count unchanged;
  - an event arriving at count=PEND_MAX is dropped, the count stays, and coin_lost pulses the next cycle.
- Issue arbiter:
  - issues when the gap counter is 0 and any pending count is >0;
  - priority is quarter > dime > nickel;
  - the chosen output is registered high for exactly 1 cycle;
  - the gap counter loads GAP_CYCLES and decrements to 0.
  - At most one coin output is high in any cycle.
- Latency from the first clock edge sampling a clean raw rise to the coin pulse: exactly DEBOUNCE_CYCLES+4 clocks when idle. The breakdown is 2 sync + DEBOUNCE_CYCLES + 1 event/pending + 1 issue.
- Coins arriving together (same cycle) issue in priority order, spaced GAP_CYCLES+1 clocks apart.
- Selections:
  - soda = stable_soda AND NOT stable_diet;
  - diet = stable_diet AND NOT stable_soda;
  - sel_conflict = stable_soda AND stable_diet;
  - all three are registered, with 1 cycle after the stable flip.

Decomposition:
- Shared package vending_pkg holds:
  - coin type encoding (COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER);
  - coin values in cents (5/10/25);
  - the default DEBOUNCE_CYCLES and GAP_CYCLES constants, also used by the Vending FSM.
- One natural sub-module: input_debouncer, holding 2-flop sync + debounce counter + stable register, parameterised by DEBOUNCE_CYCLES. Instantiate it 5 times.
- The arbiter and pending counters live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, GAP_CYCLES=2, PEND_MAX=3):
- Clean quarter_raw high for 10 clocks -> quarter high exactly 1 cycle, 8 clocks after the first sampling edge; dime=nickel=0 throughout.
- quarter_raw bounces 1,0,1,0 (1 clock each), then stays high -> exactly one quarter pulse; a 3-clock glitch alone -> no pulse.
- quarter_raw, dime_raw and nickel_raw rise in the same cycle -> pulses quarter, dime, nickel, each 3 clocks apart, never overlapping.
- 5 dimes pulsed faster than issue (events while the gap holds the queue; count reaches 3) -> coin_lost pulses for each coin dropped at count 3, and the issued dime count equals the events accepted.
- soda_raw held, then diet_raw held as well -> soda=1, then soda=0/diet=0/sel_conflict=1; release soda_raw -> diet=1, sel_conflict=0.
- Two quarters pending, reset driven 0 for 1 clock then released -> all outputs 0 immediately, with no quarter pulse after release.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin encoding, coin values and the
// timing defaults used by both the input conditioner and the Vending FSM.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_t;

  localparam logic [4:0] NICKEL_CENTS  = 5'd5;
  localparam logic [4:0] DIME_CENTS    = 5'd10;
  localparam logic [4:0] QUARTER_CENTS = 5'd25;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_GAP_CYCLES      = 2;
  localparam int DEFAULT_PEND_MAX        = 3;

  function automatic logic [4:0] coin_cents(input coin_t coin);
    logic [4:0] cents;
    case (coin)
      COIN_NICKEL:  cents = NICKEL_CENTS;
      COIN_DIME:    cents = DIME_CENTS;
      COIN_QUARTER: cents = QUARTER_CENTS;
      default:      cents = 5'd0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a hold-time debouncer for one raw contact.
// The stable value only changes after DEBOUNCE_CYCLES consecutive differing samples.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, then count how long the synchronised value disagrees with stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= '0;
      stable  <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r != stable) begin
        if (cnt_r == CNT_LAST) begin
          stable <= sync2_r;
          cnt_r  <= '0;
        end else begin
          cnt_r  <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_input_conditioner.sv
// Conditions raw coin/button contacts: debounces them, queues coin events per
// type and issues single-cycle, mutually exclusive, gap-spaced coin pulses.
module coin_input_conditioner
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int GAP_CYCLES      = DEFAULT_GAP_CYCLES,
  parameter int PEND_MAX        = DEFAULT_PEND_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic quarter_raw,
  input  logic dime_raw,
  input  logic nickel_raw,
  input  logic soda_raw,
  input  logic diet_raw,
  output logic quarter,
  output logic dime,
  output logic nickel,
  output logic soda,
  output logic diet,
  output logic sel_conflict,
  output logic coin_lost
);

  localparam int PW = $clog2(PEND_MAX + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);
  localparam logic [PW-1:0] PEND_ONE  = PW'(1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  // Channel order: 0 quarter, 1 dime, 2 nickel, 3 soda, 4 diet.
  logic [4:0]    raw_vec_s;
  logic [4:0]    stable_s;
  logic [2:0]    coin_prev_r;
  logic [2:0]    event_s;
  logic [2:0]    issue_vec_s;
  logic          lost_s;
  coin_t         issue_sel_s;
  logic [PW-1:0] pend_r     [3];
  logic [PW-1:0] pend_nxt_s [3];
  logic [GW-1:0] gap_r;

  assign raw_vec_s = {diet_raw, soda_raw, nickel_raw, dime_raw, quarter_raw};

  for (genvar ch = 0; ch < 5; ch++) begin : g_deb
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_vec_s[ch]),
      .stable (stable_s[ch])
    );
  end

  assign event_s = stable_s[2:0] & ~coin_prev_r;

  // Fixed-priority pick among non-empty queues once the gap has expired.
  always_comb begin
    issue_sel_s = COIN_NONE;
    if (gap_r == '0) begin
      if (pend_r[0] != '0) begin
        issue_sel_s = COIN_QUARTER;
      end else if (pend_r[1] != '0) begin
        issue_sel_s = COIN_DIME;
      end else if (pend_r[2] != '0) begin
        issue_sel_s = COIN_NICKEL;
      end else begin
        issue_sel_s = COIN_NONE;
      end
    end else begin
      issue_sel_s = COIN_NONE;
    end
  end

  // One-hot issue vector in channel order.
  always_comb begin
    issue_vec_s = 3'b000;
    case (issue_sel_s)
      COIN_QUARTER: issue_vec_s = 3'b001;
      COIN_DIME:    issue_vec_s = 3'b010;
      COIN_NICKEL:  issue_vec_s = 3'b100;
      default:      issue_vec_s = 3'b000;
    endcase
  end

  // Saturating pending counts; a simultaneous event and issue cancel out.
  always_comb begin
    lost_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend_nxt_s[i] = pend_r[i];
      if (event_s[i] && !issue_vec_s[i]) begin
        if (pend_r[i] == PEND_FULL) begin
          lost_s = 1'b1;
        end else begin
          pend_nxt_s[i] = pend_r[i] + PEND_ONE;
        end
      end else if (issue_vec_s[i] && !event_s[i]) begin
        pend_nxt_s[i] = pend_r[i] - PEND_ONE;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
    end
  end

  // Edge history, queues, gap timer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coin_prev_r  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        pend_r[i] <= '0;
      end
      gap_r        <= '0;
      quarter      <= 1'b0;
      dime         <= 1'b0;
      nickel       <= 1'b0;
      soda         <= 1'b0;
      diet         <= 1'b0;
      sel_conflict <= 1'b0;
      coin_lost    <= 1'b0;
    end else begin
      coin_prev_r <= stable_s[2:0];
      for (int i = 0; i < 3; i++) begin
        pend_r[i] <= pend_nxt_s[i];
      end
      if (issue_sel_s != COIN_NONE) begin
        gap_r <= GAP_LOAD;
      end else if (gap_r != '0) begin
        gap_r <= gap_r - GAP_ONE;
      end else begin
        gap_r <= gap_r;
      end
      quarter      <= issue_vec_s[0];
      dime         <= issue_vec_s[1];
      nickel       <= issue_vec_s[2];
      soda         <= stable_s[3] & ~stable_s[4];
      diet         <= stable_s[4] & ~stable_s[3];
      sel_conflict <= stable_s[3] & stable_s[4];
      coin_lost    <= lost_s;
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench: dut uses the default timing, dut_slow a long gap so the
// per-type queue can be driven into overflow and held with coins pending.
module tb_coin_input_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic quarter_raw, dime_raw, nickel_raw, soda_raw, diet_raw;
  logic quarter, dime, nickel, soda, diet, sel_conflict, coin_lost;
  logic quarter2_raw, dime2_raw, nickel2_raw, soda2_raw, diet2_raw;
  logic quarter2, dime2, nickel2, soda2, diet2, sel_conflict2, coin_lost2;

  int checks = 0;
  int failures = 0;
  int q_cnt, d_cnt, n_cnt, l_cnt, ovl_cnt;
  int q2_cnt, d2_cnt, n2_cnt, l2_cnt;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .PEND_MAX(3)
  ) dut (
    .clk(clk), .reset(reset),
    .quarter_raw(quarter_raw), .dime_raw(dime_raw), .nickel_raw(nickel_raw),
    .soda_raw(soda_raw), .diet_raw(diet_raw),
    .quarter(quarter), .dime(dime), .nickel(nickel),
    .soda(soda), .diet(diet), .sel_conflict(sel_conflict), .coin_lost(coin_lost)
  );

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(4), .GAP_CYCLES(60), .PEND_MAX(3)
  ) dut_slow (
    .clk(clk), .reset(reset),
    .quarter_raw(quarter2_raw), .dime_raw(dime2_raw), .nickel_raw(nickel2_raw),
    .soda_raw(soda2_raw), .diet_raw(diet2_raw),
    .quarter(quarter2), .dime(dime2), .nickel(nickel2),
    .soda(soda2), .diet(diet2), .sel_conflict(sel_conflict2), .coin_lost(coin_lost2)
  );

  task automatic clear_counts();
    q_cnt = 0; d_cnt = 0; n_cnt = 0; l_cnt = 0; ovl_cnt = 0;
    q2_cnt = 0; d2_cnt = 0; n2_cnt = 0; l2_cnt = 0;
  endtask

  // One clock; outputs are tallied 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (quarter) q_cnt++;
    if (dime) d_cnt++;
    if (nickel) n_cnt++;
    if (coin_lost) l_cnt++;
    if ((32'(quarter) + 32'(dime) + 32'(nickel)) > 1) ovl_cnt++;
    if (quarter2) q2_cnt++;
    if (dime2) d2_cnt++;
    if (nickel2) n2_cnt++;
    if (coin_lost2) l2_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {quarter_raw, dime_raw, nickel_raw, soda_raw, diet_raw} = 5'b0;
    {quarter2_raw, dime2_raw, nickel2_raw, soda2_raw, diet2_raw} = 5'b0;
    steps(3);
    checks++;
    if ({quarter, dime, nickel, soda, diet, sel_conflict, coin_lost} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {quarter, dime, nickel, soda, diet, sel_conflict, coin_lost});
    end
    reset = 1'b1;
    clear_counts();
    steps(5);
    checks++;
    if ({quarter2, dime2, nickel2, soda2, diet2, sel_conflict2, coin_lost2} !== 7'b0) begin
      failures++;
      $display("FAIL reset_release_slow: got %b want 0000000",
               {quarter2, dime2, nickel2, soda2, diet2, sel_conflict2, coin_lost2});
    end
  endtask

  // Raw rise sampled by edge 1 must give a quarter pulse visible right after edge 8.
  task automatic test_latency();
    logic [2:0] exp;
    clear_counts();
    quarter_raw = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      exp = {(i == 8), 1'b0, 1'b0};
      checks++;
      if ({quarter, dime, nickel} !== exp) begin
        failures++;
        $display("FAIL latency cycle %0d: qdn got %b want %b", i, {quarter, dime, nickel}, exp);
      end
      if (i == 10) quarter_raw = 1'b0;
    end
    steps(20);
    checks++;
    if (q_cnt !== 1) begin
      failures++;
      $display("FAIL latency_count: got %0d quarters want 1", q_cnt);
    end
  endtask

  task automatic test_bounce();
    clear_counts();
    quarter_raw = 1'b1; step();
    quarter_raw = 1'b0; step();
    quarter_raw = 1'b1; step();
    quarter_raw = 1'b0; step();
    quarter_raw = 1'b1; steps(12);
    quarter_raw = 1'b0; steps(20);
    checks++;
    if (q_cnt !== 1 || d_cnt !== 0 || n_cnt !== 0) begin
      failures++;
      $display("FAIL bounce: got q=%0d d=%0d n=%0d want q=1 d=0 n=0", q_cnt, d_cnt, n_cnt);
    end
    clear_counts();
    quarter_raw = 1'b1; steps(3);
    quarter_raw = 1'b0; steps(20);
    checks++;
    if (q_cnt !== 0) begin
      failures++;
      $display("FAIL glitch3: got %0d quarters want 0", q_cnt);
    end
    clear_counts();
    quarter_raw = 1'b1; steps(4);
    quarter_raw = 1'b0; steps(20);
    checks++;
    if (q_cnt !== 1) begin
      failures++;
      $display("FAIL glitch4: got %0d quarters want 1", q_cnt);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp;
    clear_counts();
    {quarter_raw, dime_raw, nickel_raw} = 3'b111;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp = {(i == 8), (i == 11), (i == 14)};
      checks++;
      if ({quarter, dime, nickel} !== exp) begin
        failures++;
        $display("FAIL simultaneous cycle %0d: qdn got %b want %b", i, {quarter, dime, nickel}, exp);
      end
      if (i == 10) {quarter_raw, dime_raw, nickel_raw} = 3'b000;
    end
    steps(15);
    checks++;
    if (q_cnt !== 1 || d_cnt !== 1 || n_cnt !== 1 || ovl_cnt !== 0) begin
      failures++;
      $display("FAIL simultaneous_totals: got q=%0d d=%0d n=%0d overlap=%0d want 1 1 1 0",
               q_cnt, d_cnt, n_cnt, ovl_cnt);
    end
  endtask

  task automatic test_selection();
    logic [2:0] exp;
    soda_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      exp = (i >= 7) ? 3'b100 : 3'b000;
      checks++;
      if ({soda, diet, sel_conflict} !== exp) begin
        failures++;
        $display("FAIL sel_soda cycle %0d: sdc got %b want %b", i, {soda, diet, sel_conflict}, exp);
      end
    end
    diet_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      exp = (i >= 7) ? 3'b001 : 3'b100;
      checks++;
      if ({soda, diet, sel_conflict} !== exp) begin
        failures++;
        $display("FAIL sel_conflict cycle %0d: sdc got %b want %b", i, {soda, diet, sel_conflict}, exp);
      end
    end
    soda_raw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      exp = (i >= 7) ? 3'b010 : 3'b001;
      checks++;
      if ({soda, diet, sel_conflict} !== exp) begin
        failures++;
        $display("FAIL sel_diet cycle %0d: sdc got %b want %b", i, {soda, diet, sel_conflict}, exp);
      end
    end
    diet_raw = 1'b0;
    steps(9);
    checks++;
    if ({soda, diet, sel_conflict} !== 3'b000) begin
      failures++;
      $display("FAIL sel_release: sdc got %b want 000", {soda, diet, sel_conflict});
    end
  endtask

  // Six dimes 10 clocks apart against a 60-clock gap: one issues, three queue, two drop.
  task automatic test_overflow();
    clear_counts();
    for (int k = 0; k < 6; k++) begin
      dime2_raw = 1'b1; steps(5);
      dime2_raw = 1'b0; steps(5);
    end
    steps(250);
    checks++;
    if (d2_cnt !== 4) begin
      failures++;
      $display("FAIL overflow_issued: got %0d dimes want 4", d2_cnt);
    end
    checks++;
    if (l2_cnt !== 2) begin
      failures++;
      $display("FAIL overflow_lost: got %0d coin_lost pulses want 2", l2_cnt);
    end
    checks++;
    if (q2_cnt !== 0 || n2_cnt !== 0 || l_cnt !== 0) begin
      failures++;
      $display("FAIL overflow_other: got q2=%0d n2=%0d lost1=%0d want 0 0 0", q2_cnt, n2_cnt, l_cnt);
    end
  endtask

  task automatic test_reset_midway();
    clear_counts();
    soda2_raw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      quarter2_raw = 1'b1; steps(5);
      quarter2_raw = 1'b0; steps(5);
    end
    checks++;
    if (q2_cnt !== 1 || soda2 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got quarters=%0d soda=%b want 1 and 1", q2_cnt, soda2);
    end
    reset = 1'b0;
    soda2_raw = 1'b0;
    #1;
    checks++;
    if ({quarter2, dime2, nickel2, soda2, diet2, sel_conflict2, coin_lost2} !== 7'b0) begin
      failures++;
      $display("FAIL reset_async: got %b want 0000000",
               {quarter2, dime2, nickel2, soda2, diet2, sel_conflict2, coin_lost2});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_counts();
    steps(150);
    checks++;
    if (q2_cnt !== 0 || d2_cnt !== 0 || n2_cnt !== 0 || l2_cnt !== 0) begin
      failures++;
      $display("FAIL reset_discard: got q=%0d d=%0d n=%0d lost=%0d want all 0",
               q2_cnt, d2_cnt, n2_cnt, l2_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_simultaneous();
    test_selection();
    test_overflow();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
